// File: rtl/i2c_master_tx.sv
// I2C single-byte write master: START, address+W, ACK, data byte, ACK, STOP.
// SCL is push-pull; SDA is open-drain and read back for the ACK slots.
module i2c_master_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       scl,
  inout  wire        sda
);

  localparam int QW = $clog2(CLK_DIV) + 1;

  typedef enum logic [2:0] {IDLE, START, ADDR, ACK_ADDR, DATA, ACK_DATA, STOP} state_t;

  state_t        state, nxt;
  logic [QW-1:0] qcnt;
  logic [1:0]    qidx;
  logic [2:0]    bcnt;
  logic [7:0]    sr, dbyte;
  logic          ack_hi, sda_oe;
  logic          qend, slot_end, ack_smp;

  assign qend     = (qcnt == QW'(CLK_DIV - 1));
  assign slot_end = qend && (qidx == 2'd3);
  // ACK is read on the last clk of Q2, well after SCL has risen
  assign ack_smp  = (state == ACK_ADDR || state == ACK_DATA) && (qidx == 2'd2) && qend;
  assign sda      = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt    = state;
    scl    = 1'b1;
    sda_oe = 1'b0;
    case (state)
      IDLE:     if (start && !busy) nxt = START;
      START: begin
        sda_oe = qidx[1];
        if (slot_end) nxt = ADDR;
      end
      ADDR: begin
        scl    = qidx[1];
        sda_oe = ~sr[7];
        if (slot_end && bcnt == 3'd7) nxt = ACK_ADDR;
      end
      ACK_ADDR: begin
        scl = qidx[1];
        if (slot_end) nxt = ack_hi ? STOP : DATA;
      end
      DATA: begin
        scl    = qidx[1];
        sda_oe = ~sr[7];
        if (slot_end && bcnt == 3'd7) nxt = ACK_DATA;
      end
      ACK_DATA: begin
        scl = qidx[1];
        if (slot_end) nxt = STOP;
      end
      STOP: begin
        scl    = qidx[1];
        sda_oe = (qidx != 2'd3);
        if (slot_end) nxt = IDLE;
      end
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      qcnt   <= '0;
      qidx   <= '0;
      bcnt   <= '0;
      sr     <= '0;
      dbyte  <= '0;
      ack_hi <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      nack   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        qcnt <= '0;
        qidx <= '0;
        bcnt <= '0;
        if (start && !busy) begin
          sr    <= {addr, 1'b0};
          dbyte <= data_in;
          busy  <= 1'b1;
          nack  <= 1'b0;
        end
      end else begin
        qcnt <= qend ? '0 : qcnt + QW'(1);
        if (qend) qidx <= qidx + 2'd1;
        if (slot_end && (state == ADDR || state == DATA)) begin
          sr   <= {sr[6:0], 1'b0};
          bcnt <= bcnt + 3'd1;
        end
        if (slot_end && state == ACK_ADDR) sr <= dbyte;
        if (ack_smp) begin
          ack_hi <= sda;
          if (sda) nack <= 1'b1;
        end
        if (slot_end && state == STOP) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule
